cnn_core_sched: RTL and testbench
=================================

Name: cnn_core_sched

Overview:
- Sequences one output-feature-map pass through the convolution core.
- On start: soft-resets the core, then walks every output pixel in raster order and issues one in_valid per pixel. Each issue carries the window's top-left input coordinates to the window-fetch logic.
- A credit counter bounds in-flight pixels to the downstream buffer depth.
- Returned core outputs are counted; done is signalled when all have come back.

Parameters:
- C_BW, 8, width of coordinate and size fields.
- MAX_INFLIGHT, 4, max pixels issued but not yet returned by the core (1..15).
- IF_BW, 4, width of the in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- start_i  input  1  one-cycle start pulse; ignored unless IDLE
- abort_i  input  1  abandon current pass
- cfg_ox_i  input  C_BW  output width in pixels, sampled on accepted start
- cfg_oy_i  input  C_BW  output height in pixels, sampled on accepted start
- cfg_stride_i  input  2  window stride 1..3 (0 treated as 1), sampled on start
- stall_i  input  1  window fetch not ready; no issue this cycle
- core_ot_valid_i  input  1  core output valid (one per issued pixel)
- core_soft_reset_o  output  1  soft reset to core
- core_in_valid_o  output  1  issue one window to core
- win_x_o  output  C_BW  input column of window top-left
- win_y_o  output  C_BW  input row of window top-left
- busy_o  output  1  not IDLE
- done_o  output  1  one-cycle pass-complete pulse
- err_o  output  1  sticky: core output received with zero in flight

Behaviour:
- Reset values: all outputs 0; FSM IDLE; counters 0; err_o 0.
- All outputs are registered.

FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.

IDLE:
- On start_i: latch cfg_ox_i, cfg_oy_i, cfg_stride_i.
- Clear err_o and all counters; go to CLEAR.

CLEAR:
- core_soft_reset_o = 1 for exactly one cycle.
- If cfg_ox or cfg_oy is 0: go to DONE (no issues).
- Otherwise: go to RUN.

RUN:
- Issue condition: !stall_i AND (inflight < MAX_INFLIGHT OR core_ot_valid_i this cycle).
- When the condition holds: core_in_valid_o = 1 next cycle, with win_x_o = x*stride and win_y_o = y*stride for the current (x,y).
- Coordinate stepping: x increments; when x = ox-1, x wraps to 0 and y increments.
- win_x/win_y use running stride accumulators, not multipliers.
- After the issue at (ox-1, oy-1): go to DRAIN.
- core_in_valid_o is 0 in every cycle with no issue.

DRAIN:
- No issues.
- When inflight == 0 and the returned count == ox*oy: go to DONE.

DONE:
- done_o = 1 for one cycle; go to IDLE.

In-flight counter:
- +1 on issue, -1 on core_ot_valid_i; a simultaneous issue and return leaves it unchanged.
- It never exceeds MAX_INFLIGHT.

Returned counter:
- Width 2*C_BW; increments on each core_ot_valid_i while busy.

Error:
- core_ot_valid_i while inflight == 0 (any state, including IDLE) sets err_o.
- The counter is not decremented below 0 in that case.

Abort:
- abort_i in CLEAR, RUN or DRAIN: go to CLEAR, then IDLE (not DONE).
- The core is soft-reset; counters are zeroed; done_o is not pulsed.
- In-flight results are discarded because the core is reset.

Other rules:
- start_i while busy is ignored; the latched config is unchanged.
- Latency: start_i at cycle 0 → core_soft_reset_o at cycle 1 → first core_in_valid_o at cycle 2, if not stalled and credit is available.
- reset_n low mid-pass: immediate return to reset values; no done_o.

Test Plan:
- ox=3, oy=2, stride=1, no stall, core returns each pixel 2 cycles after issue → 6 issues with coordinates (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); soft_reset at cycle 1; done_o once after the 6th return; busy_o falls the cycle after done_o.
- ox=2, oy=2, stride=2 → win coordinates (0,0),(2,0),(0,2),(2,2).
- MAX_INFLIGHT=4, ox=8, oy=1, core never returns → exactly 4 issues, then core_in_valid_o stays 0. Releasing returns one per cycle → an issue each cycle with a simultaneous return; inflight never exceeds 4.
- stall_i high for cycles 3–5 during a 4x1 pass → no core_in_valid_o while stalled; coordinates resume without skipping; 4 total issues.
- abort_i mid-RUN after 3 issues of a 4x4 pass → one soft_reset pulse, back to IDLE, no done_o. A new start with ox=1, oy=1 completes with exactly 1 issue and done_o.
- ox=0 → soft_reset pulse, then done_o with zero issues. core_ot_valid_i while IDLE → err_o=1, held until the next accepted start.

Source files
------------

// File: rtl/cnn_core_sched.sv
// cnn_core_sched: sequences one output-feature-map pass through the conv core.
// Soft-resets the core, issues one window per output pixel in raster order under
// a credit limit, counts returns and pulses done_o when all have come back.
// Ports: clk/reset_n; start_i, abort_i, cfg_ox_i, cfg_oy_i, cfg_stride_i (control);
// stall_i, core_ot_valid_i (flow); core_soft_reset_o, core_in_valid_o,
// win_x_o, win_y_o (core side); busy_o, done_o, err_o (status).
module cnn_core_sched #(
  parameter int C_BW         = 8,
  parameter int MAX_INFLIGHT = 4,
  parameter int IF_BW        = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [C_BW-1:0] cfg_ox_i,
  input  logic [C_BW-1:0] cfg_oy_i,
  input  logic [1:0]      cfg_stride_i,
  input  logic            stall_i,
  input  logic            core_ot_valid_i,
  output logic            core_soft_reset_o,
  output logic            core_in_valid_o,
  output logic [C_BW-1:0] win_x_o,
  output logic [C_BW-1:0] win_y_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int R_BW = 2 * C_BW;
  localparam logic [IF_BW-1:0] MAX_IF = IF_BW'(MAX_INFLIGHT);
  localparam logic [IF_BW-1:0] ONE_IF = IF_BW'(1);
  localparam logic [C_BW-1:0]  ONE_C  = C_BW'(1);
  localparam logic [R_BW-1:0]  ONE_R  = R_BW'(1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;

  logic [C_BW-1:0]  ox;
  logic [C_BW-1:0]  oy;
  logic [1:0]       stride;
  logic [R_BW-1:0]  total;
  logic [C_BW-1:0]  x;
  logic [C_BW-1:0]  y;
  logic [C_BW-1:0]  wx;
  logic [C_BW-1:0]  wy;
  logic [IF_BW-1:0] inflight;
  logic [R_BW-1:0]  ret_cnt;
  // Set while CLEAR is the soft-reset leg of an abort; it then returns to IDLE.
  logic             aborting;

  logic             bad_ret;
  logic             ret_ok;
  logic             issue_ok;
  logic             do_issue;
  logic             x_last;
  logic             y_last;
  logic             size_zero;
  logic [C_BW-1:0]  stride_w;
  logic [IF_BW-1:0] inf_nxt;

  always_comb begin
    bad_ret   = core_ot_valid_i && (inflight == '0);
    ret_ok    = core_ot_valid_i && (inflight != '0);
    // A return in the same cycle frees a credit for this issue.
    issue_ok  = !stall_i &&
                ((inflight < MAX_IF) || core_ot_valid_i);
    x_last    = (x == ox - ONE_C);
    y_last    = (y == oy - ONE_C);
    size_zero = (ox == '0) || (oy == '0);
    stride_w  = C_BW'(stride);
    // The first window is decided in CLEAR so it reaches the
    // core the cycle after the soft reset.
    do_issue  = 1'b0;
    if (!abort_i && issue_ok) begin
      if (state == RUN)
        do_issue = 1'b1;
      if (state == CLEAR && !aborting && !size_zero)
        do_issue = 1'b1;
    end
    inf_nxt = inflight;
    case ({do_issue, ret_ok})
      2'b10:   inf_nxt = inflight + ONE_IF;
      2'b01:   inf_nxt = inflight - ONE_IF;
      default: inf_nxt = inflight;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      ox                <= '0;
      oy                <= '0;
      stride            <= '0;
      total             <= '0;
      x                 <= '0;
      y                 <= '0;
      wx                <= '0;
      wy                <= '0;
      inflight          <= '0;
      ret_cnt           <= '0;
      aborting          <= 1'b0;
      core_soft_reset_o <= 1'b0;
      core_in_valid_o   <= 1'b0;
      win_x_o           <= '0;
      win_y_o           <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      err_o             <= 1'b0;
    end else begin
      core_soft_reset_o <= 1'b0;
      core_in_valid_o   <= 1'b0;
      done_o            <= 1'b0;
      inflight          <= inf_nxt;

      if (state != IDLE && core_ot_valid_i)
        ret_cnt <= ret_cnt + ONE_R;

      if (do_issue) begin
        core_in_valid_o <= 1'b1;
        win_x_o         <= wx;
        win_y_o         <= wy;
        if (x_last) begin
          x  <= '0;
          wx <= '0;
          y  <= y + ONE_C;
          wy <= wy + stride_w;
        end else begin
          x  <= x + ONE_C;
          wx <= wx + stride_w;
        end
      end

      unique case (state)
        IDLE: begin
          if (start_i) begin
            ox                <= cfg_ox_i;
            oy                <= cfg_oy_i;
            stride            <= (cfg_stride_i == 2'd0) ? 2'd1
                                                        : cfg_stride_i;
            total             <= R_BW'(cfg_ox_i) * R_BW'(cfg_oy_i);
            err_o             <= 1'b0;
            x                 <= '0;
            y                 <= '0;
            wx                <= '0;
            wy                <= '0;
            inflight          <= '0;
            ret_cnt           <= '0;
            aborting          <= 1'b0;
            core_soft_reset_o <= 1'b1;
            busy_o            <= 1'b1;
            state             <= CLEAR;
          end
        end
        CLEAR: begin
          if (abort_i) begin
            state <= CLEAR;
          end else if (aborting) begin
            aborting <= 1'b0;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end else if (size_zero) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else if (do_issue && x_last && y_last) begin
            state <= DRAIN;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (do_issue && x_last && y_last)
            state <= DRAIN;
        end
        DRAIN: begin
          if (inflight == '0 && ret_cnt == total) begin
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase

      // Abort wins over every other update: the core is reset,
      // so anything still in flight is simply forgotten.
      if (abort_i && (state == CLEAR || state == RUN ||
                      state == DRAIN)) begin
        state             <= CLEAR;
        aborting          <= 1'b1;
        core_soft_reset_o <= 1'b1;
        done_o            <= 1'b0;
        x                 <= '0;
        y                 <= '0;
        wx                <= '0;
        wy                <= '0;
        inflight          <= '0;
        ret_cnt           <= '0;
      end

      if (bad_ret)
        err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cnn_core_sched.sv
// tb_cnn_core_sched: directed passes with a scoreboard of expected windows.
// A behavioural core model returns results; a monitor checks each issue.
module tb_cnn_core_sched;

  logic       clk;
  logic       reset_n;
  logic       start_i;
  logic       abort_i;
  logic [7:0] cfg_ox_i;
  logic [7:0] cfg_oy_i;
  logic [1:0] cfg_stride_i;
  logic       stall_i;
  logic       core_ot_valid_i;
  logic       core_soft_reset_o;
  logic       core_in_valid_o;
  logic [7:0] win_x_o;
  logic [7:0] win_y_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  cnn_core_sched #(
    .C_BW(8),
    .MAX_INFLIGHT(4),
    .IF_BW(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start_i(start_i),
    .abort_i(abort_i),
    .cfg_ox_i(cfg_ox_i),
    .cfg_oy_i(cfg_oy_i),
    .cfg_stride_i(cfg_stride_i),
    .stall_i(stall_i),
    .core_ot_valid_i(core_ot_valid_i),
    .core_soft_reset_o(core_soft_reset_o),
    .core_in_valid_o(core_in_valid_o),
    .win_x_o(win_x_o),
    .win_y_o(win_y_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int issues = 0;
  int sr_cnt = 0;
  int done_cnt = 0;
  int ret_total = 0;
  int max_due = 0;
  int ret_lat = 2;
  bit hold_ret = 0;
  bit inject_ret = 0;
  logic [15:0] exp_q[$];
  int due[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Core model: one result per issued window, ret_lat cycles
  // later, unless held; everything is lost on soft reset.
  initial begin
    bit ot;
    core_ot_valid_i = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n || core_soft_reset_o) begin
        due.delete();
      end else if (core_in_valid_o) begin
        due.push_back(cyc + ret_lat);
        if (due.size() > max_due) max_due = due.size();
      end
      ot = 0;
      if (!hold_ret && due.size() > 0 && due[0] <= cyc) begin
        ot = 1;
        void'(due.pop_front());
        ret_total++;
      end
      core_ot_valid_i = ot | inject_ret;
    end
  end

  // Monitor: pops the expected window for every issue.
  initial forever begin
    logic [15:0] e;
    @(negedge clk);
    if (core_in_valid_o) begin
      issues++;
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", {win_x_o, win_y_o}, 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("win_xy", {win_x_o, win_y_o}, e);
      end
    end
    if (core_soft_reset_o) sr_cnt++;
    if (done_o) done_cnt++;
  end

  task automatic push_pass(input int ox, input int oy, input int st);
    for (int yy = 0; yy < oy; yy++)
      for (int xx = 0; xx < ox; xx++)
        exp_q.push_back({8'(xx * st), 8'(yy * st)});
  endtask

  // Leaves the bench in cycle 1 (the soft-reset cycle).
  task automatic start_pass(input int ox, input int oy, input int st);
    tick();
    cfg_ox_i = 8'(ox);
    cfg_oy_i = 8'(oy);
    cfg_stride_i = 2'(st);
    start_i = 1;
    tick();
    start_i = 0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    int n;
    n = 0;
    while (!done_o && n < lim) begin
      tick();
      n++;
    end
    if (!done_o) begin
      chk({nm, "_done_timeout"}, 0, 1);
    end else begin
      chk({nm, "_busy_at_done"}, busy_o, 1);
      tick();
      chk({nm, "_busy_after"}, busy_o, 0);
    end
  endtask

  initial begin
    int d0;
    int s0;
    reset_n = 0;
    start_i = 0;
    abort_i = 0;
    cfg_ox_i = 0;
    cfg_oy_i = 0;
    cfg_stride_i = 0;
    stall_i = 0;
    repeat (3) tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_inv", core_in_valid_o, 0);
    chk("rst_sr", core_soft_reset_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_win", {win_x_o, win_y_o}, 0);
    reset_n = 1;
    repeat (2) tick();

    // 3x2 stride 1, return latency 2
    issues = 0; d0 = done_cnt; ret_total = 0;
    push_pass(3, 2, 1);
    start_pass(3, 2, 1);
    chk("t1_sr_c1", core_soft_reset_o, 1);
    chk("t1_inv_c1", core_in_valid_o, 0);
    tick();
    chk("t1_inv_c2", core_in_valid_o, 1);
    chk("t1_sr_c2", core_soft_reset_o, 0);
    wait_done("t1", 100);
    repeat (3) tick();
    chk("t1_issues", issues, 6);
    chk("t1_returns", ret_total, 6);
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_err", err_o, 0);

    // 2x2 stride 2
    issues = 0;
    push_pass(2, 2, 2);
    start_pass(2, 2, 2);
    wait_done("t2", 100);
    chk("t2_issues", issues, 4);
    chk("t2_q_empty", exp_q.size(), 0);

    // 8x1 with the core holding all results
    issues = 0; max_due = 0; ret_lat = 1; hold_ret = 1;
    push_pass(8, 1, 1);
    start_pass(8, 1, 1);
    repeat (14) tick();
    chk("t3_credit_issues", issues, 4);
    chk("t3_inv_blocked", core_in_valid_o, 0);
    cfg_ox_i = 2; cfg_oy_i = 2; cfg_stride_i = 3;
    start_i = 1;
    tick();
    start_i = 0;
    hold_ret = 0;
    repeat (5) tick();
    chk("t3_back2back", issues, 8);
    wait_done("t3", 100);
    chk("t3_max_inflight", max_due, 4);
    chk("t3_q_empty", exp_q.size(), 0);
    ret_lat = 2;

    // 4x1 with stall over cycles 3..5
    issues = 0;
    push_pass(4, 1, 1);
    start_pass(4, 1, 1);
    tick();
    tick();
    stall_i = 1;
    tick();
    chk("t4_stall_c4", core_in_valid_o, 0);
    tick();
    chk("t4_stall_c5", core_in_valid_o, 0);
    tick();
    chk("t4_stall_c6", core_in_valid_o, 0);
    stall_i = 0;
    wait_done("t4", 100);
    chk("t4_issues", issues, 4);

    // abort a 4x4 pass after 3 issues
    issues = 0; d0 = done_cnt; hold_ret = 1;
    push_pass(3, 1, 1);
    start_pass(4, 4, 1);
    repeat (3) tick();
    chk("t5_pre_abort", issues, 3);
    s0 = sr_cnt;
    abort_i = 1;
    tick();
    abort_i = 0;
    chk("t5_abort_sr", core_soft_reset_o, 1);
    tick();
    chk("t5_idle", busy_o, 0);
    repeat (5) tick();
    chk("t5_sr_once", sr_cnt - s0, 1);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_issues", issues, 3);
    hold_ret = 0;
    issues = 0; d0 = done_cnt;
    push_pass(1, 1, 1);
    start_pass(1, 1, 1);
    wait_done("t5b", 50);
    chk("t5b_issues", issues, 1);
    chk("t5b_done", done_cnt - d0, 1);
    chk("t5b_err", err_o, 0);

    // empty pass, then a stray return in IDLE
    issues = 0; s0 = sr_cnt;
    start_pass(0, 5, 1);
    wait_done("t6", 20);
    chk("t6_issues", issues, 0);
    chk("t6_sr", sr_cnt - s0, 1);
    tick();
    inject_ret = 1;
    tick();
    inject_ret = 0;
    tick();
    tick();
    chk("t6_err_set", err_o, 1);
    repeat (4) tick();
    chk("t6_err_held", err_o, 1);
    push_pass(1, 1, 1);
    start_pass(1, 1, 1);
    chk("t6_err_clr", err_o, 0);
    wait_done("t6b", 50);

    // reset in the middle of a pass
    d0 = done_cnt; hold_ret = 1;
    push_pass(4, 4, 1);
    start_pass(4, 4, 1);
    repeat (3) tick();
    reset_n = 0;
    #1;
    chk("t7_rst_busy", busy_o, 0);
    chk("t7_rst_inv", core_in_valid_o, 0);
    tick();
    reset_n = 1;
    hold_ret = 0;
    exp_q.delete();
    repeat (5) tick();
    chk("t7_no_done", done_cnt - d0, 0);
    chk("t7_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
